// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, FSM state type and frame check
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_t;

  // Field order matches the shift register once all 11 bits are in (start at bit 0).
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] code;
    logic       start;
  } ps2_frame_t;

  function automatic logic frame_ok(input ps2_frame_t f);
    return (f.start == START_BIT) && (f.stop == STOP_BIT) && (^{f.code, f.parity});
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - show-ahead scan-code FIFO with push/pop/full/empty
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard frame receiver feeding a scan-code FIFO
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_s1, clk_s2, clk_hist;
  logic dat_s1, dat_s2;
  logic fall;

  rx_state_t              state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic [TO_W-1:0]        idle_cnt;
  ps2_frame_t             next_frame;
  logic                   last_bit;
  logic                   timeout_hit;

  logic       push_q;
  logic [7:0] push_code;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_hist && !clk_s2;

  // Bits arrive LSB first, so shifting in at the top leaves the start bit at bit 0.
  assign next_frame  = ps2_frame_t'({dat_s2, shreg[FRAME_BITS-1:1]});
  assign last_bit    = (state == ST_RECV) && fall && (bit_cnt == LAST_CNT);
  assign timeout_hit = (state == ST_RECV) && !fall && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (fall) begin
            state   <= ST_RECV;
            bit_cnt <= BIT_CNT_W'(1);
            shreg   <= {dat_s2, {(FRAME_BITS-1){1'b0}}};
          end
        end
        ST_RECV: begin
          if (fall) begin
            idle_cnt <= '0;
            shreg    <= next_frame;
            if (bit_cnt == LAST_CNT) begin
              state   <= ST_IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  // Frame verdict is registered; the push and the error pulse share the cycle after the 11th edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q    <= 1'b0;
      push_code <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      push_q    <= last_bit && frame_ok(next_frame);
      push_code <= next_frame.code;
      frame_err <= last_bit && !frame_ok(next_frame);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full && !rd_en) begin
      overflow <= 1'b1;
    end
  end

  ps2_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .push_data(push_code),
    .pop      (rd_en),
    .pop_data (data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ready = !fifo_empty;

endmodule
